// File: rtl/bus_pkg.sv
// Shared definitions for the memory-bus arbiter and the DMA masters that sit on it:
// FSM state encoding, default bus widths, DMA register addresses, index-width helper.
package bus_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  // DMA engine register map on the shared bus
  localparam logic [31:0] DMA_CTRL_ADDR = 32'd5000;
  localparam logic [31:0] DMA_STAT_ADDR = 32'd5004;
  localparam logic [31:0] DMA_SRC_ADDR  = 32'd5008;
  localparam logic [31:0] DMA_DST_ADDR  = 32'd5012;
  localparam logic [31:0] DMA_LEN_ADDR  = 32'd5016;

  // Bits needed to index n masters; never below 1 so single-master builds stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin picker: rotate requests so ptr sits at bit 0, take the lowest set bit,
// rotate the one-hot result back. Purely combinational.
module rr_pick
  import bus_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] win_o,
  output logic            vld_o
);

  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] oh;
  logic [IW:0]     sum;
  logic [IW-1:0]   k;

  always_comb begin
    rot   = '0;
    oh    = '0;
    win_o = '0;
    sum   = '0;
    k     = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, IW'(i)} + {1'b0, ptr_i};
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      k = sum[IW-1:0];
      rot[i] = req_i[k];
    end
    // isolate lowest set bit of the rotated vector
    oh = rot & (~rot + NREQ'(1));
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, IW'(i)} + {1'b0, ptr_i};
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      k = sum[IW-1:0];
      win_o[k] = oh[i];
    end
  end

  assign vld_o = |req_i;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin request/grant arbiter for the shared memory bus with a one-cycle
// turnaround between owners. Define ARB_HOLD_LIMIT_EN to cap ownership at MAX_HOLD cycles.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int AW       = BUS_AW,
  parameter int DW       = BUS_DW,
  parameter int MAX_HOLD = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NREQ-1:0]      Req,
  output logic [NREQ-1:0]      Gnt,
  input  logic [NREQ*AW-1:0]   M_Addr,
  input  logic [NREQ*DW-1:0]   M_WData,
  input  logic [NREQ-1:0]      M_Read,
  input  logic [NREQ-1:0]      M_Write,
  output logic [AW-1:0]        Bus_Addr,
  output logic [DW-1:0]        Bus_WData,
  output logic                 Bus_Read,
  output logic                 Bus_Write,
  output logic                 Busy,
  output logic                 Err
);

  localparam int IW = idx_w(NREQ);

  if (NREQ < 1 || NREQ > 8 || MAX_HOLD < 2) begin : g_cfg_err
    $error("bus_arbiter: NREQ must be 1..8 and MAX_HOLD >= 2");
  end

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] win;
  logic            win_vld;
  logic [IW-1:0]   own_idx;
  logic [IW-1:0]   ptr_nxt;
  logic            own_req;
  logic            hold_lim;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i (Req),
    .ptr_i (ptr_q),
    .win_o (win),
    .vld_o (win_vld)
  );

  always_comb begin
    own_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt_q[i]) own_idx = IW'(i);
  end

  assign own_req = |(Req & gnt_q);
  assign ptr_nxt = (own_idx == IW'(NREQ-1)) ? '0 : own_idx + IW'(1);

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] hold_q, hold_d;

  assign hold_lim = (hold_q == HW'(MAX_HOLD-1));

  always_comb begin
    hold_d = hold_q;
    if (state_q == ST_GRANT) hold_d = hold_q + HW'(1);
    else                     hold_d = '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  assign hold_lim = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE, ST_RELEASE: begin
        // both arbitrate; RELEASE only differs in having just cleared the grant
        if (win_vld) begin
          gnt_d   = win;
          state_d = ST_GRANT;
        end else begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!own_req || hold_lim) begin
          gnt_d   = '0;
          state_d = ST_RELEASE;
          ptr_d   = ptr_nxt;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

  // AND-OR mux keyed by the one-hot grant: zero with no owner, no tristates
  logic rd, wr;
  always_comb begin
    Bus_Addr  = '0;
    Bus_WData = '0;
    rd        = 1'b0;
    wr        = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        Bus_Addr  = M_Addr[i*AW +: AW];
        Bus_WData = M_WData[i*DW +: DW];
        rd        = M_Read[i];
        wr        = M_Write[i];
      end
    end
  end

  assign Bus_Write = wr;
  assign Bus_Read  = rd & ~wr;
  assign Err       = rd & wr;
  assign Gnt       = gnt_q;
  assign Busy      = |gnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic against a
// round-robin reference model that tracks owner and pointer as plain integers.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MH = 4;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [N-1:0]    Req, Gnt, M_Read, M_Write;
  logic [N*AW-1:0] M_Addr;
  logic [N*DW-1:0] M_WData;
  logic [AW-1:0]   Bus_Addr;
  logic [DW-1:0]   Bus_WData;
  logic            Bus_Read, Bus_Write, Busy, Err;

  int n_chk  = 0;
  int n_fail = 0;

  int m_owner, m_ptr, m_hold;

  bus_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .MAX_HOLD(MH)) dut (
    .CLK(CLK), .RST_N(RST_N), .Req(Req), .Gnt(Gnt),
    .M_Addr(M_Addr), .M_WData(M_WData), .M_Read(M_Read), .M_Write(M_Write),
    .Bus_Addr(Bus_Addr), .Bus_WData(Bus_WData), .Bus_Read(Bus_Read),
    .Bus_Write(Bus_Write), .Busy(Busy), .Err(Err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
  endtask

  // One clock edge of the arbitration rules.
  task automatic model_edge();
    bit lim;
    int w;
`ifdef ARB_HOLD_LIMIT_EN
    lim = (m_hold == MH - 1);
`else
    lim = 1'b0;
`endif
    if (m_owner >= 0) begin
      if (!Req[m_owner] || lim) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_hold++;
      end
    end else begin
      w = pick(Req, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_hold  = 0;
      end
    end
  endtask

  task automatic check_outputs(input string ph);
    logic [N-1:0]  eg;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          er, ew, ee;
    eg = '0; ea = '0; ed = '0; er = 0; ew = 0; ee = 0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ea = M_Addr[m_owner*AW +: AW];
      ed = M_WData[m_owner*DW +: DW];
      ew = M_Write[m_owner];
      er = M_Read[m_owner] & ~M_Write[m_owner];
      ee = M_Read[m_owner] & M_Write[m_owner];
    end
    chk({ph, ".gnt"},   Gnt,       eg);
    chk({ph, ".busy"},  Busy,      |eg);
    chk({ph, ".addr"},  Bus_Addr,  ea);
    chk({ph, ".wdata"}, Bus_WData, ed);
    chk({ph, ".rd"},    Bus_Read,  er);
    chk({ph, ".wr"},    Bus_Write, ew);
    chk({ph, ".err"},   Err,       ee);
  endtask

  task automatic run_cycle(input string ph);
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_outputs(ph);
  endtask

  task automatic clear_inputs();
    Req = '0; M_Read = '0; M_Write = '0; M_Addr = '0; M_WData = '0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    clear_inputs();
    #2;
    model_reset();
    check_outputs("reset");
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    RST_N = 1'b0;
    clear_inputs();
    model_reset();

    // single requester, read access appears on the bus
    do_reset();
    Req = 4'b0001;
    M_Addr[0 +: AW] = 32'h100;
    M_Read[0] = 1'b1;
    run_cycle("s1");
    chk("s1.gnt_const", Gnt, 4'b0001);
    chk("s1.busy_const", Busy, 1'b1);
    chk("s1.addr_const", Bus_Addr, 32'h100);
    chk("s1.rd_const", Bus_Read, 1'b1);

    // two requesters from ptr=0, one-cycle turnaround between owners
    do_reset();
    Req = 4'b1010;
    run_cycle("s2");
    chk("s2.first", Gnt, 4'b0010);
    run_cycle("s2");
    Req = 4'b1000;
    run_cycle("s2");
    chk("s2.turn", Gnt, 4'b0000);
    run_cycle("s2");
    chk("s2.second", Gnt, 4'b1000);

    // both strobes from owner: write wins and Err pulses
    do_reset();
    Req = 4'b0100;
    run_cycle("s3");
    M_Read = 4'b0100;
    M_Write = 4'b0100;
    M_WData[2*DW +: DW] = 32'hDEAD_BEEF;
    #1;
    chk("s3.wr", Bus_Write, 1'b1);
    chk("s3.rd", Bus_Read, 1'b0);
    chk("s3.wdata", Bus_WData, 32'hDEAD_BEEF);
    chk("s3.err", Err, 1'b1);
    run_cycle("s3");
    M_Read = '0;
    M_Write = '0;
    #1;
    chk("s3.err_clr", Err, 1'b0);

    // hold limit behaviour with two permanent requesters
    do_reset();
    Req = 4'b0011;
    for (int i = 0; i < 14; i++) begin
      logic [N-1:0] eg;
`ifdef ARB_HOLD_LIMIT_EN
      if (i % (MH + 1) == MH) eg = 4'b0000;
      else eg = ((i / (MH + 1)) % 2 == 0) ? 4'b0001 : 4'b0010;
`else
      eg = 4'b0001;
`endif
      run_cycle("hold");
      chk("hold.pattern", Gnt, eg);
    end

    // asynchronous reset in the middle of a grant
    do_reset();
    Req = 4'b0001;
    M_Addr[0 +: AW] = 32'hABC0;
    M_Write[0] = 1'b1;
    run_cycle("ar");
    run_cycle("ar");
    @(posedge CLK);
    model_edge();
    #3;
    RST_N = 1'b0;
    #1;
    chk("ar.gnt", Gnt, 4'b0000);
    chk("ar.addr", Bus_Addr, 32'h0);
    chk("ar.wr", Bus_Write, 1'b0);
    chk("ar.busy", Busy, 1'b0);
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    clear_inputs();
    Req = 4'b0100;
    run_cycle("ar");
    chk("ar.regrant", Gnt, 4'b0100);

    // all four requesting, each owner leaves after two cycles
    do_reset();
    begin
      int got = 0;
      for (int c = 0; c < 60 && got < 5; c++) begin
        Req = 4'b1111;
        if (m_owner >= 0 && m_hold >= 1) Req[m_owner] = 1'b0;
        run_cycle("rr");
        if (m_owner >= 0 && m_hold == 0) begin
          chk("rr.order", oh_idx(Gnt), got % N);
          got++;
        end
      end
      chk("rr.count", got, 5);
    end

    // random traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (i == m_owner) Req[i] = ($urandom_range(0, 7) != 0);
        else              Req[i] = ($urandom_range(0, 2) == 0);
        M_Addr[i*AW +: AW]  = $urandom;
        M_WData[i*DW +: DW] = $urandom;
      end
      M_Read  = N'($urandom);
      M_Write = N'($urandom_range(0, 3) == 0 ? $urandom : 0);
      run_cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
